// File: rtl/seg7_pkg.sv
// Shared 7-segment constants: hex segment table, all-off pattern, width helper.
// Latency: n/a (constants and an elaboration-time function only).
// Backpressure: n/a.
package seg7_pkg;

  // Active-high segment pattern a..g = [6:0] with every segment dark
  localparam logic [6:0] SEG_OFF = 7'b0000000;

  // Active-high hex glyphs, a = bit 6 ... g = bit 0
  localparam logic [6:0] SEG_HEX [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  // Bits needed to hold 0..v-1, never less than 1
  function automatic int clog2(input int v);
    int w;
    w = 1;
    while ((1 << w) < v) w++;
    return w;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Nibble to active-high 7-segment glyph, usable by any display block.
// Latency: combinational.
// Backpressure: none.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Plain table lookup; polarity is left to the caller
  always_comb begin
    seg = SEG_HEX[nibble];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment scanner with anti-ghost blanking and tear-free updates.
// Latency: an/seg/dp_out/frame_start are registered, one cycle behind the scan counters.
// Backpressure: none; load is a fire-and-forget strobe, last load before a frame boundary wins.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_HZ       = 100000000,
  parameter int REFRESH_HZ   = 1000,
  parameter int BLANK_CYCLES = 64,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp_out,
  output logic                    frame_start
);

  localparam int TICK_DIV = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int PW       = clog2(TICK_DIV);
  localparam int DW       = clog2(NUM_DIGITS);

  localparam logic [PW-1:0] PS_LAST  = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PS_BLANK = PW'(BLANK_CYCLES);
  localparam logic [DW-1:0] DG_LAST  = DW'(NUM_DIGITS - 1);

  // Polarity masks: XOR an active-high value with these at the output flops
  localparam logic          POL      = (ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_POL = {NUM_DIGITS{POL}};
  localparam logic [6:0]    SEG_POL  = {7{POL}};

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("seg7_scan_driver: NUM_DIGITS must be 1..8");
  end
  if (TICK_DIV < 2 || BLANK_CYCLES >= TICK_DIV) begin : g_bad_timing
    $error("seg7_scan_driver: need TICK_DIV>=2 and BLANK_CYCLES<TICK_DIV");
  end

  logic [PW-1:0] prescaler;
  logic [DW-1:0] digit;
  logic          frame_end;

  logic [NUM_DIGITS-1:0][3:0] sh_val;
  logic [NUM_DIGITS-1:0]      sh_dp;
  logic [NUM_DIGITS-1:0]      sh_blank;
  logic                       pending;

  logic [NUM_DIGITS-1:0][3:0] disp_val;
  logic [NUM_DIGITS-1:0]      disp_dp;
  logic [NUM_DIGITS-1:0]      disp_blank;

  logic [3:0]            cur_nib;
  logic [6:0]            cur_pat;
  logic                  lit;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic [6:0]            seg_nxt;
  logic                  dp_nxt;

  assign frame_end = (prescaler == PS_LAST) && (digit == DG_LAST);

  // Slot prescaler and digit index; frame_start marks the cycle after a frame boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler   <= '0;
      digit       <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_end;
      if (prescaler == PS_LAST) begin
        prescaler <= '0;
        digit     <= (digit == DG_LAST) ? '0 : digit + DW'(1);
      end else begin
        prescaler <= prescaler + PW'(1);
      end
    end
  end

  // Shadow capture and frame-boundary transfer so the visible frame is never torn
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_val     <= '0;
      sh_dp      <= '0;
      sh_blank   <= '0;
      pending    <= 1'b0;
      disp_val   <= '0;
      disp_dp    <= '0;
      disp_blank <= '0;
    end else if (load && frame_end) begin
      // Load on the boundary itself skips the shadow and lands in the next frame
      disp_val   <= value;
      disp_dp    <= dp;
      disp_blank <= blank;
      pending    <= 1'b0;
    end else if (load) begin
      sh_val   <= value;
      sh_dp    <= dp;
      sh_blank <= blank;
      pending  <= 1'b1;
    end else if (frame_end && pending) begin
      disp_val   <= sh_val;
      disp_dp    <= sh_dp;
      disp_blank <= sh_blank;
      pending    <= 1'b0;
    end
  end

  assign cur_nib = disp_val[digit];

  seg7_hex_decode u_dec (
    .nibble (cur_nib),
    .seg    (cur_pat)
  );

  // Active-high next outputs: dark during the blanking window, when disabled or digit blanked
  always_comb begin
    lit     = enable && (prescaler >= PS_BLANK) && !disp_blank[digit];
    an_nxt  = '0;
    seg_nxt = SEG_OFF;
    dp_nxt  = 1'b0;
    if (lit) begin
      an_nxt  = NUM_DIGITS'(1) << digit;
      seg_nxt = cur_pat;
      dp_nxt  = disp_dp[digit];
    end
  end

  // Output flops apply pin polarity in one place; reset leaves every pin inactive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an     <= AN_POL;
      seg    <= SEG_OFF ^ SEG_POL;
      dp_out <= POL;
    end else begin
      an     <= an_nxt ^ AN_POL;
      seg    <= seg_nxt ^ SEG_POL;
      dp_out <= dp_nxt ^ POL;
    end
  end

endmodule
